// File: rtl/r5p_htif_pkg.sv
// HTIF controller shared types and encoding constants.
package r5p_htif_pkg;

    // Controller run state; HALT and TOUT are terminal until reset.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TOUT = 2'd2
    } htif_st_t;

    // tohost bit 0 set marks an exit request; the remaining bits carry the exit code.
    localparam int unsigned HTIF_EXIT_BIT = 0;

    // Device/command ids of the HTIF console; reserved, not decoded here.
    localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
    localparam logic [7:0] HTIF_CMD_PUTC    = 8'd1;

    // An exit request needs the exit bit written and its byte lane enabled.
    function automatic logic htif_is_exit(input logic i_wdt0, input logic i_ben0);
        return i_wdt0 & i_ben0;
    endfunction

endpackage

// File: rtl/r5p_htif_ctl_if.sv
// TCB load/store request bundle covering HRT channels.
interface tcb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned HRT  = 1
) ();

    localparam int unsigned BENW = XLEN / 8;

    logic [HRT-1:0]  trn;
    logic [HRT-1:0]  req_wen;
    logic [XLEN-1:0] req_adr [HRT];
    logic [XLEN-1:0] req_wdt [HRT];
    logic [BENW-1:0] req_ben [HRT];

    modport master  (output trn, req_wen, req_adr, req_wdt, req_ben);
    modport slave   (input  trn, req_wen, req_adr, req_wdt, req_ben);
    modport monitor (input  trn, req_wen, req_adr, req_wdt, req_ben);

endinterface

// File: rtl/r5p_htif_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module r5p_htif_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdat,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_rdat
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_pop;
    logic          w_push;

    // Status flags and accepted handshakes; a pop in the same cycle frees room for a push.
    always_comb begin
        o_empty = (r_wptr == r_rptr);
        o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_pop   = i_pop & ~o_empty;
        w_push  = i_push & (~o_full | w_pop);
        o_rdat  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    end

    // Read/write pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage, cleared on reset so no stale byte survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdat;
        end
    end

endmodule

// File: rtl/r5p_htif_ctl.sv
// HTIF controller: snoops TCB writes for tohost exit and console output, plus a cycle timeout.
module r5p_htif_ctl
    import r5p_htif_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned HRT  = 1,
    parameter int unsigned CNW  = 32,
    parameter int unsigned TMO  = 10000,
    parameter int unsigned FDP  = 16
) (
    input  logic            clk,
    input  logic            rst,
    tcb_if.monitor          tcb,
    input  logic [XLEN-1:0] i_tohost,
    input  logic [XLEN-1:0] i_conadr,
    output logic            o_halt,
    output logic            o_pass,
    output logic [XLEN-2:0] o_code,
    output logic            o_tout,
    output logic [CNW-1:0]  o_cnt,
    output logic            o_con_vld,
    input  logic            i_con_rdy,
    output logic [7:0]      o_con_dat,
    output logic            o_con_drp
);

    localparam logic [CNW-1:0] TMO_CNT = CNW'(TMO - 1);

    htif_st_t        r_st;
    htif_st_t        w_st_nxt;
    logic [XLEN-2:0] r_code;
    logic [CNW-1:0]  r_cnt;
    logic            r_drp;

    logic [HRT-1:0]  w_th_hit;
    logic [HRT-1:0]  w_cn_hit;
    logic            w_th_any;
    logic [XLEN-1:0] w_th_wdt;
    logic            w_th_ben0;
    logic            w_cn_any;
    logic            w_cn_multi;
    logic [7:0]      w_cn_dat;
    logic            w_exit;
    logic            w_tmo;
    logic            w_cnt_en;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_drop;

    // Per-channel address hits on tohost and the console byte.
    always_comb begin
        w_th_hit = '0;
        w_cn_hit = '0;
        for (int i = 0; i < HRT; i++) begin
            w_th_hit[i] = tcb.trn[i] & tcb.req_wen[i] & (tcb.req_adr[i] == i_tohost);
            w_cn_hit[i] = tcb.trn[i] & tcb.req_wen[i] & (tcb.req_adr[i] == i_conadr)
                        & tcb.req_ben[i][0];
        end
    end

    // Priority encoders: the lowest-index hit wins; extra console hits are flagged.
    always_comb begin
        w_th_any   = 1'b0;
        w_th_wdt   = '0;
        w_th_ben0  = 1'b0;
        w_cn_any   = 1'b0;
        w_cn_multi = 1'b0;
        w_cn_dat   = '0;
        for (int i = 0; i < HRT; i++) begin
            if (w_th_hit[i] && !w_th_any) begin
                w_th_any  = 1'b1;
                w_th_wdt  = tcb.req_wdt[i];
                w_th_ben0 = tcb.req_ben[i][0];
            end
            if (w_cn_hit[i]) begin
                if (w_cn_any) begin
                    w_cn_multi = 1'b1;
                end else begin
                    w_cn_any = 1'b1;
                    w_cn_dat = tcb.req_wdt[i][7:0];
                end
            end
        end
        w_exit = w_th_any & htif_is_exit(w_th_wdt[HTIF_EXIT_BIT], w_th_ben0);
        w_tmo  = (TMO != 0) && (r_cnt == TMO_CNT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_st <= RUN;
        else     r_st <= w_st_nxt;
    end

    // Next state: halt has priority over a coincident timeout.
    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            RUN: begin
                if (w_exit)     w_st_nxt = HALT;
                else if (w_tmo) w_st_nxt = TOUT;
            end
            default: w_st_nxt = r_st;
        endcase
    end

    // State-derived outputs and counter enable; the counter stops on the leaving edge.
    always_comb begin
        o_halt   = (r_st == HALT);
        o_tout   = (r_st == TOUT);
        o_pass   = o_halt & (r_code == '0);
        o_code   = r_code;
        o_cnt    = r_cnt;
        w_cnt_en = (r_st == RUN) & (w_st_nxt == RUN) & (r_cnt != '1);
    end

    // Exit code capture on the halting write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_code <= '0;
        else if (r_st == RUN && w_exit) r_code <= w_th_wdt[XLEN-1:1];
    end

    // Saturating cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_cnt <= '0;
        else if (w_cnt_en) r_cnt <= r_cnt + 1'b1;
    end

    // Sticky drop flag: extra same-cycle console hits or a push into a full FIFO with no pop.
    always_comb begin
        w_pop  = i_con_rdy & ~w_empty;
        w_drop = w_cn_multi | (w_cn_any & w_full & ~w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_drp <= 1'b0;
        else if (w_drop) r_drp <= 1'b1;
    end

    assign o_con_drp = r_drp;
    assign o_con_vld = ~w_empty;

    r5p_htif_fifo #(
        .DW    (8),
        .DEPTH (FDP)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cn_any),
        .i_wdat  (w_cn_dat),
        .i_pop   (i_con_rdy),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdat  (o_con_dat)
    );

endmodule

// File: tb/tb_r5p_htif_ctl.sv
// Directed and randomized bench for r5p_htif_ctl against a queue-based reference model.
module tb_r5p_htif_ctl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned HRT  = 2;
    localparam int unsigned CNW  = 32;
    localparam int unsigned TMO  = 100;
    localparam int unsigned FDP  = 4;

    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam logic [31:0] CONADR = 32'h8000_2000;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] tohost;
    logic [XLEN-1:0] conadr;
    logic            halt;
    logic            pass;
    logic [XLEN-2:0] code;
    logic            tout;
    logic [CNW-1:0]  cnt;
    logic            con_vld;
    logic            con_rdy;
    logic [7:0]      con_dat;
    logic            con_drp;

    int n_tests;
    int n_fail;

    // Reference model state
    bit          m_halt;
    bit          m_tout;
    bit [30:0]   m_code;
    int unsigned m_cnt;
    bit          m_drp;
    bit [7:0]    m_q[$];

    tcb_if #(.XLEN(XLEN), .HRT(HRT)) tcb ();

    r5p_htif_ctl #(
        .XLEN (XLEN),
        .HRT  (HRT),
        .CNW  (CNW),
        .TMO  (TMO),
        .FDP  (FDP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tcb       (tcb),
        .i_tohost  (tohost),
        .i_conadr  (conadr),
        .o_halt    (halt),
        .o_pass    (pass),
        .o_code    (code),
        .o_tout    (tout),
        .o_cnt     (cnt),
        .o_con_vld (con_vld),
        .i_con_rdy (con_rdy),
        .o_con_dat (con_dat),
        .o_con_drp (con_drp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_halt = 0;
        m_tout = 0;
        m_code = '0;
        m_cnt  = 0;
        m_drp  = 0;
        m_q.delete();
    endtask

    // One clock of the reference model, from the inputs about to be sampled.
    task automatic m_step();
        bit pop;
        int cfirst;
        int tfirst;
        pop    = (m_q.size() != 0) && con_rdy;
        cfirst = -1;
        tfirst = -1;
        for (int c = 0; c < HRT; c++) begin
            if (tcb.trn[c] && tcb.req_wen[c] && tcb.req_adr[c] == conadr && tcb.req_ben[c][0]) begin
                if (cfirst < 0) cfirst = c;
                else            m_drp = 1;
            end
            if (tcb.trn[c] && tcb.req_wen[c] && tcb.req_adr[c] == tohost && tfirst < 0)
                tfirst = c;
        end
        if (pop) void'(m_q.pop_front());
        if (cfirst >= 0) begin
            if (m_q.size() < FDP) m_q.push_back(tcb.req_wdt[cfirst][7:0]);
            else                  m_drp = 1;
        end
        if (!m_halt && !m_tout) begin
            if (tfirst >= 0 && tcb.req_wdt[tfirst][0] && tcb.req_ben[tfirst][0]) begin
                m_halt = 1;
                m_code = tcb.req_wdt[tfirst][31:1];
            end else if (m_cnt == TMO - 1) begin
                m_tout = 1;
            end else if (m_cnt != 32'hFFFF_FFFF) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_model();
        chk("halt", 64'(halt), 64'(m_halt));
        chk("pass", 64'(pass), 64'(m_halt && m_code == 0));
        chk("code", 64'(code), 64'(m_code));
        chk("tout", 64'(tout), 64'(m_tout));
        chk("cnt", 64'(cnt), 64'(m_cnt));
        chk("con_vld", 64'(con_vld), 64'(m_q.size() != 0));
        chk("con_dat", 64'(con_dat), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
        chk("con_drp", 64'(con_drp), 64'(m_drp));
    endtask

    task automatic drive_idle();
        for (int c = 0; c < HRT; c++) begin
            tcb.trn[c]     = 1'b0;
            tcb.req_wen[c] = 1'b0;
            tcb.req_adr[c] = '0;
            tcb.req_wdt[c] = '0;
            tcb.req_ben[c] = '0;
        end
    endtask

    task automatic drive_wr(input int ch, input logic [31:0] adr, input logic [31:0] wdt,
                            input logic [3:0] ben);
        tcb.trn[ch]     = 1'b1;
        tcb.req_wen[ch] = 1'b1;
        tcb.req_adr[ch] = adr;
        tcb.req_wdt[ch] = wdt;
        tcb.req_ben[ch] = ben;
    endtask

    // Advance one clock with the current inputs, then compare against the model.
    task automatic cycle();
        m_step();
        @(posedge clk);
        #1;
        check_model();
        drive_idle();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        drive_idle();
        con_rdy = 1'b0;
        rst     = 1'b1;
        m_reset();
        #1;
        check_model();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tohost  = TOHOST;
        conadr  = CONADR;
        rst     = 1'b0;
        con_rdy = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;

        // Pass halt at cycle 50
        do_reset();
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        idle_cycles(50);
        drive_wr(0, TOHOST, 32'h1, 4'hF);
        cycle();
        chk("pass_halt", 64'(halt), 64'd1);
        chk("pass_pass", 64'(pass), 64'd1);
        chk("pass_code", 64'(code), 64'd0);
        chk("pass_cnt", 64'(cnt), 64'd50);
        idle_cycles(5);
        chk("pass_cnt_frozen", 64'(cnt), 64'd50);

        // Fail halt; bit-0-clear writes are ignored, later exits don't overwrite
        do_reset();
        idle_cycles(5);
        drive_wr(0, TOHOST, 32'h4, 4'hF);
        cycle();
        chk("cmd_ignored", 64'(halt), 64'd0);
        drive_wr(0, TOHOST, 32'hB, 4'hF);
        cycle();
        chk("fail_halt", 64'(halt), 64'd1);
        chk("fail_pass", 64'(pass), 64'd0);
        chk("fail_code", 64'(code), 64'd5);
        drive_wr(0, TOHOST, 32'h1, 4'hF);
        cycle();
        chk("fail_code_kept", 64'(code), 64'd5);

        // Timeout
        do_reset();
        idle_cycles(99);
        chk("tmo_pre_tout", 64'(tout), 64'd0);
        chk("tmo_pre_cnt", 64'(cnt), 64'd99);
        cycle();
        chk("tmo_tout", 64'(tout), 64'd1);
        chk("tmo_cnt", 64'(cnt), 64'd99);
        idle_cycles(4);
        chk("tmo_cnt_frozen", 64'(cnt), 64'd99);

        // Halt and timeout coincide: halt wins
        do_reset();
        idle_cycles(99);
        drive_wr(0, TOHOST, 32'h1, 4'hF);
        cycle();
        chk("tie_halt", 64'(halt), 64'd1);
        chk("tie_tout", 64'(tout), 64'd0);

        // Console stream "HI\n"
        do_reset();
        con_rdy = 1'b1;
        drive_wr(0, CONADR, 32'h48, 4'h1);
        cycle();
        chk("con_h_vld", 64'(con_vld), 64'd1);
        chk("con_h_dat", 64'(con_dat), 64'h48);
        con_rdy = 1'b1;
        drive_wr(0, CONADR, 32'h49, 4'h1);
        cycle();
        chk("con_i_dat", 64'(con_dat), 64'h49);
        con_rdy = 1'b1;
        drive_wr(0, CONADR, 32'h0A, 4'h1);
        cycle();
        chk("con_nl_dat", 64'(con_dat), 64'h0A);
        idle_cycles(1);
        chk("con_done_vld", 64'(con_vld), 64'd0);

        // FIFO full and drop
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_wr(0, CONADR, 32'(8'h31 + k), 4'h1);
            cycle();
        end
        chk("full_drp", 64'(con_drp), 64'd1);
        chk("full_head", 64'(con_dat), 64'h31);
        con_rdy = 1'b1;
        idle_cycles(4);
        chk("full_drained", 64'(con_vld), 64'd0);

        // Push and pop in the same cycle while full: no drop
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_wr(0, CONADR, 32'(8'h61 + k), 4'h1);
            cycle();
        end
        chk("pp_no_drp_pre", 64'(con_drp), 64'd0);
        con_rdy = 1'b1;
        drive_wr(0, CONADR, 32'h65, 4'h1);
        cycle();
        chk("pp_no_drp", 64'(con_drp), 64'd0);
        chk("pp_head", 64'(con_dat), 64'h62);
        con_rdy = 1'b1;
        idle_cycles(4);

        // Two channels hit the console together, then reset with FIFO non-empty
        do_reset();
        drive_wr(0, CONADR, 32'h41, 4'h1);
        drive_wr(1, CONADR, 32'h42, 4'h1);
        cycle();
        chk("multi_drp", 64'(con_drp), 64'd1);
        chk("multi_dat", 64'(con_dat), 64'h41);
        idle_cycles(1);
        rst = 1'b1;
        m_reset();
        #1;
        chk("mrst_vld", 64'(con_vld), 64'd0);
        chk("mrst_dat", 64'(con_dat), 64'd0);
        chk("mrst_drp", 64'(con_drp), 64'd0);
        chk("mrst_cnt", 64'(cnt), 64'd0);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized console traffic across both channels with random back-pressure
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < HRT; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    tcb.trn[c]     = 1'b1;
                    tcb.req_wen[c] = ($urandom_range(0, 3) != 0);
                    tcb.req_adr[c] = ($urandom_range(0, 2) != 0) ? CONADR
                                   : 32'h9000_0000 + 32'($urandom_range(0, 255));
                    tcb.req_wdt[c] = $urandom;
                    tcb.req_ben[c] = 4'($urandom_range(0, 15));
                end
            end
            con_rdy = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
